// File: rtl/rca_pipe_addsub_if.sv
// rtl/rca_pipe_addsub_if.sv - operand/result handshake bundle for the pipelined adder/subtractor
interface rca_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_pipe_addsub.sv
// rtl/rca_pipe_addsub.sv - pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage
module rca_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rca_pipe_addsub_if.slave   bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The whole pipe moves as one: a stalled consumer freezes every stage.
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    // Subtraction is folded into the first slice: invert B once, force carry-in.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub | bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : stage
        localparam int DONE = (k + 1) * CHUNK;
        localparam int REM  = WIDTH - DONE;

        logic             valid_in;
        logic             carry_in;
        logic [CHUNK-1:0] a_s;
        logic [CHUNK-1:0] b_s;
        logic [DONE-1:0]  sum_new;
        logic [CHUNK:0]   c;
        logic [CHUNK-1:0] s;
        logic             load;

        logic             valid_d, valid_q;
        logic [DONE-1:0]  sum_d, sum_q;
        logic             carry_d, carry_q;

        if (k == 0) begin : g_src
            assign valid_in = bus.in_valid;
            assign carry_in = cin_eff;
            assign a_s      = bus.a[CHUNK-1:0];
            assign b_s      = b_eff[CHUNK-1:0];
            assign sum_new  = s;
        end else begin : g_src
            assign valid_in = stage[k-1].valid_q;
            assign carry_in = stage[k-1].carry_q;
            assign a_s      = stage[k-1].g_opnd.a_q[CHUNK-1:0];
            assign b_s      = stage[k-1].g_opnd.b_q[CHUNK-1:0];
            assign sum_new  = {s, stage[k-1].sum_q};
        end

        always_comb begin
            c    = '0;
            s    = '0;
            c[0] = carry_in;
            for (int i = 0; i < CHUNK; i++) begin
                s[i]   = a_s[i] ^ b_s[i] ^ c[i];
                c[i+1] = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
            end
        end

        // Data registers only load on a real operation so results hold across bubbles.
        assign load = adv & valid_in;

        always_comb begin
            valid_d = adv ? valid_in : valid_q;
            sum_d   = load ? sum_new : sum_q;
            carry_d = load ? c[CHUNK] : carry_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        if (REM > 0) begin : g_opnd
            logic [REM-1:0] a_nxt, b_nxt;
            logic [REM-1:0] a_d, a_q;
            logic [REM-1:0] b_d, b_q;

            if (k == 0) begin : g_nxt
                assign a_nxt = bus.a[WIDTH-1:CHUNK];
                assign b_nxt = b_eff[WIDTH-1:CHUNK];
            end else begin : g_nxt
                assign a_nxt = stage[k-1].g_opnd.a_q[CHUNK +: REM];
                assign b_nxt = stage[k-1].g_opnd.b_q[CHUNK +: REM];
            end

            always_comb begin
                a_d = load ? a_nxt : a_q;
                b_d = load ? b_nxt : b_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == LAST) begin : g_last
            logic ovf_d, ovf_q;

            // Signed overflow: carry into the MSB disagrees with carry out of it.
            always_comb begin
                ovf_d = load ? (c[CHUNK] ^ c[CHUNK-1]) : ovf_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign bus.out_valid = stage[LAST].valid_q;
    assign bus.sum       = stage[LAST].sum_q;
    assign bus.cout      = stage[LAST].carry_q;
    assign bus.ovf       = stage[LAST].g_last.ovf_q;
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb/tb_rca_pipe_addsub.sv - scoreboard bench over several WIDTH/STAGES configurations
module tb_rca_pipe_addsub;
    localparam int NCFG = 5;
    localparam int DIR  = 2;

    function automatic int cfg_w(int i);
        return (i == 4) ? 32 : 16;
    endfunction

    function automatic int cfg_s(int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 16;
            default: return 8;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCFG-1:0] in_valid_v = '0;
    logic [NCFG-1:0] cin_v = '0;
    logic [NCFG-1:0] sub_v = '0;
    logic [NCFG-1:0] out_ready_v = '1;
    logic [NCFG-1:0] in_ready_v, out_valid_v, cout_v, ovf_v;
    logic [31:0]     a_arr [NCFG];
    logic [31:0]     b_arr [NCFG];
    logic [31:0]     sum_arr [NCFG];

    exp_t sb [NCFG][$];
    int   accepted [NCFG];
    int   consumed [NCFG];
    int   tests_run = 0;
    int   tests_failed = 0;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);

        rca_pipe_addsub_if #(.WIDTH(W)) bus ();

        assign bus.in_valid  = in_valid_v[g];
        assign bus.a         = a_arr[g][W-1:0];
        assign bus.b         = b_arr[g][W-1:0];
        assign bus.cin       = cin_v[g];
        assign bus.sub       = sub_v[g];
        assign bus.out_ready = out_ready_v[g];
        assign in_ready_v[g]  = bus.in_ready;
        assign out_valid_v[g] = bus.out_valid;
        assign sum_arr[g]     = 32'(bus.sum);
        assign cout_v[g]      = bus.cout;
        assign ovf_v[g]       = bus.ovf;

        rca_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    function automatic exp_t ref_calc(int i, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        int          w;
        logic [32:0] mask, am, bm, full;
        exp_t        e;
        w     = cfg_w(i);
        mask  = (33'd1 << w) - 33'd1;
        am    = {1'b0, a} & mask;
        bm    = (sub ? {1'b0, ~b} : {1'b0, b}) & mask;
        full  = am + bm + {32'd0, (sub | cin)};
        e.sum  = full[31:0] & mask[31:0];
        e.cout = full[w];
        e.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        return e;
    endfunction

    // Transfers are observed mid-cycle, then the clock edge commits them.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            if (rst_n && out_valid_v[i] && out_ready_v[i]) begin
                consumed[i]++;
                tests_run++;
                if (sb[i].size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected cfg%0d: got sum=%h with nothing outstanding", i, sum_arr[i]);
                end else begin
                    e = sb[i].pop_front();
                    if ({sum_arr[i], cout_v[i], ovf_v[i]} !== e) begin
                        tests_failed++;
                        $display("FAIL sb_result cfg%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 i, sum_arr[i], cout_v[i], ovf_v[i], e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (rst_n && in_valid_v[i] && in_ready_v[i]) begin
                accepted[i]++;
                sb[i].push_back(ref_calc(i, a_arr[i], b_arr[i], cin_v[i], sub_v[i]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, logic v, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        in_valid_v[i] = v;
        a_arr[i] = a;
        b_arr[i] = b;
        cin_v[i] = cin;
        sub_v[i] = sub;
    endtask

    task automatic apply_reset(int cycles);
        in_valid_v = '0;
        out_ready_v = '1;
        rst_n = 1'b0;
        for (int i = 0; i < NCFG; i++) sb[i].delete();
        for (int c = 0; c < cycles; c++) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(2);
        tests_run++;
        if (out_valid_v[DIR] !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid_v[DIR]);
        end
        tests_run++;
        if (sum_arr[DIR] !== 32'h0) begin
            tests_failed++; $display("FAIL reset_sum: got %h want 0000", sum_arr[DIR]);
        end
        tests_run++;
        if (in_ready_v[DIR] !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready_v[DIR]);
        end
        drive(DIR, 1'b1, 32'h0008, 32'h0002, 1'b0, 1'b0);
        tick();
        in_valid_v[DIR] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tests_run++;
            if (out_valid_v[DIR] !== (k == 4)) begin
                tests_failed++; $display("FAIL first_latency cycle %0d: got out_valid=%b want %b", k, out_valid_v[DIR], (k == 4));
            end
            if (k < 4) tick();
        end
        tests_run++;
        if ({sum_arr[DIR], cout_v[DIR], ovf_v[DIR]} !== {32'h000A, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL first_result: got sum=%h cout=%b ovf=%b want sum=000a cout=0 ovf=0",
                                     sum_arr[DIR], cout_v[DIR], ovf_v[DIR]);
        end
        tick();
    endtask

    task automatic run_table(string name, logic [15:0] ta [3], logic [15:0] tb [3], logic [2:0] tc,
                             logic [2:0] ts, logic [15:0] es [3], logic [2:0] ec, logic [2:0] eo);
        int waited;
        for (int j = 0; j < 3; j++) begin
            drive(DIR, 1'b1, {16'h0, ta[j]}, {16'h0, tb[j]}, tc[j], ts[j]);
            tick();
        end
        in_valid_v[DIR] = 1'b0;
        waited = 0;
        while (!out_valid_v[DIR] && waited < 10) begin
            tick();
            waited++;
        end
        for (int j = 0; j < 3; j++) begin
            tests_run++;
            if ({out_valid_v[DIR], sum_arr[DIR], cout_v[DIR], ovf_v[DIR]} !== {1'b1, 16'h0, es[j], ec[j], eo[j]}) begin
                tests_failed++;
                $display("FAIL %s op%0d: got valid=%b sum=%h cout=%b ovf=%b want valid=1 sum=%h cout=%b ovf=%b",
                         name, j, out_valid_v[DIR], sum_arr[DIR], cout_v[DIR], ovf_v[DIR], es[j], ec[j], eo[j]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [3], tb [3], es [3];
        ta = '{16'h0008, 16'h8000, 16'h0048};
        tb = '{16'h0002, 16'h0302, 16'hFFFF};
        es = '{16'h000B, 16'h8302, 16'h0047};
        run_table("back_to_back", ta, tb, 3'b001, 3'b000, es, 3'b100, 3'b000);
    endtask

    task automatic test_sub();
        logic [15:0] ta [3], tb [3], es [3];
        ta = '{16'h8000, 16'h0000, 16'h7FFF};
        tb = '{16'h0001, 16'h0001, 16'h0001};
        es = '{16'h7FFF, 16'hFFFF, 16'h8000};
        run_table("sub_ovf", ta, tb, 3'b010, 3'b011, es, 3'b001, 3'b101);
    endtask

    task automatic test_stall();
        int base_acc, base_con, stall_left, n, cyc;
        bit stall_done;
        logic [31:0] held;
        base_acc = accepted[DIR];
        base_con = consumed[DIR];
        stall_left = 0;
        stall_done = 0;
        held = '0;
        cyc = 0;
        while ((consumed[DIR] - base_con) < 6 && cyc < 80) begin
            n = accepted[DIR] - base_acc;
            drive(DIR, n < 6, 32'h1111 * n + 32'h0F, 32'h0301 * n, n[0], n[1]);
            if (!stall_done && (consumed[DIR] - base_con) >= 2) begin
                stall_left = 3;
                stall_done = 1;
            end
            out_ready_v[DIR] = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                tests_run++;
                if (in_ready_v[DIR] !== 1'b0) begin
                    tests_failed++; $display("FAIL stall_in_ready: got %b want 0", in_ready_v[DIR]);
                end
                if (stall_left < 3) begin
                    tests_run++;
                    if (sum_arr[DIR] !== held) begin
                        tests_failed++; $display("FAIL stall_sum_hold: got %h want %h", sum_arr[DIR], held);
                    end
                end
                held = sum_arr[DIR];
                stall_left--;
            end
            tick();
            cyc++;
        end
        in_valid_v[DIR] = 1'b0;
        out_ready_v[DIR] = 1'b1;
        tests_run++;
        if ((consumed[DIR] - base_con) != 6 || (accepted[DIR] - base_acc) != 6 || !stall_done) begin
            tests_failed++;
            $display("FAIL stall_count: got accepted=%0d consumed=%0d stalled=%0d want 6 6 1",
                     accepted[DIR] - base_acc, consumed[DIR] - base_con, stall_done);
        end
    endtask

    task automatic test_reset_mid();
        int seen, lat;
        drive(DIR, 1'b1, 32'h0101, 32'h0202, 1'b0, 1'b0);
        tick();
        drive(DIR, 1'b1, 32'h0303, 32'h0404, 1'b1, 1'b0);
        tick();
        apply_reset(1);
        tests_run++;
        if (in_ready_v[DIR] !== 1'b1) begin
            tests_failed++; $display("FAIL reset_mid_in_ready: got %b want 1", in_ready_v[DIR]);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid_v[DIR]) seen++;
            tick();
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++; $display("FAIL reset_mid_flush: got %0d valid cycles want 0", seen);
        end
        drive(DIR, 1'b1, 32'h1234, 32'h1111, 1'b0, 1'b0);
        tick();
        in_valid_v[DIR] = 1'b0;
        lat = 1;
        while (!out_valid_v[DIR] && lat < 12) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat != 4 || sum_arr[DIR] !== 32'h2345) begin
            tests_failed++; $display("FAIL reset_mid_next: got latency=%0d sum=%h want latency=4 sum=2345", lat, sum_arr[DIR]);
        end
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_8000;
            3:       return 32'h7FFF_7FFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NCFG; i++) begin
                drive(i, $urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                out_ready_v[i] = $urandom_range(0, 4) != 0;
            end
            tick();
        end
        in_valid_v = '0;
        out_ready_v = '1;
        for (int c = 0; c < 40; c++) tick();
        for (int i = 0; i < NCFG; i++) begin
            tests_run++;
            if (sb[i].size() != 0 || accepted[i] != consumed[i] || accepted[i] < 100) begin
                tests_failed++;
                $display("FAIL random_drain cfg%0d: got pending=%0d accepted=%0d consumed=%0d want pending=0 and equal counts",
                         i, sb[i].size(), accepted[i], consumed[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
            accepted[i] = 0;
            consumed[i] = 0;
        end
        test_reset();
        test_back_to_back();
        test_sub();
        test_stall();
        test_reset_mid();
        apply_reset(2);
        for (int i = 0; i < NCFG; i++) begin
            accepted[i] = 0;
            consumed[i] = 0;
        end
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
